// File: rtl/display_sequencer.sv
// Safe display sequencer: gathers four keypad digits, hands the code to the
// verifier, then shows the result or a timed error on the 4-digit display.
module display_sequencer #(
  parameter int ERR_CYCLES    = 100,
  parameter int IDLE_CYCLES   = 1000,
  parameter int VERIFY_CYCLES = 64,
  parameter int TMR_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  input  logic        verify_done,
  input  logic        verify_ok,
  output logic        code_valid,
  output logic [15:0] entered_code,
  output logic [2:0]  display_mode,
  output logic [2:0]  digit_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_WAIT,
    S_ERR
  } state_t;

  localparam logic [2:0] MODE_ERR   = 3'b001;
  localparam logic [2:0] MODE_SHOW  = 3'b010;
  localparam logic [2:0] MODE_BLANK = 3'b100;

  localparam logic [TMR_W-1:0] ERR_LAST  = TMR_W'(ERR_CYCLES - 1);
  localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(IDLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] VER_LAST  = TMR_W'(VERIFY_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = '1;

  state_t            state;
  state_t            state_n;
  logic [TMR_W-1:0]  tmr;
  logic [TMR_W-1:0]  tmr_n;
  logic              tmr_rst;
  logic [15:0]       code_n;
  logic [2:0]        cnt_n;
  logic              cv_n;
  logic [2:0]        mode_n;
  logic              busy_n;
  logic              digit_ok;

  assign digit_ok = key_valid && (key_digit <= 4'd9);

  always_comb begin
    state_n = state;
    code_n  = entered_code;
    cnt_n   = digit_count;
    cv_n    = 1'b0;
    tmr_rst = 1'b0;
    unique case (state)
      S_IDLE: begin
        code_n = 16'h0;
        cnt_n  = 3'd0;
        if (digit_ok && !key_clear) begin
          code_n  = {12'h0, key_digit};
          cnt_n   = 3'd1;
          state_n = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (key_clear) begin
          code_n  = 16'h0;
          cnt_n   = 3'd0;
          state_n = S_IDLE;
        end else if (digit_ok) begin
          code_n  = {entered_code[11:0], key_digit};
          cnt_n   = 3'(digit_count + 3'd1);
          tmr_rst = 1'b1;
          if (digit_count == 3'd3) begin
            cv_n    = 1'b1;
            state_n = S_WAIT;
          end
        end else if (tmr >= IDLE_LAST) begin
          code_n  = 16'h0;
          cnt_n   = 3'd0;
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        // a response landing on the timeout cycle still counts
        if (verify_done) begin
          code_n  = 16'h0;
          cnt_n   = 3'd0;
          state_n = verify_ok ? S_IDLE : S_ERR;
        end else if (tmr >= VER_LAST) begin
          code_n  = 16'h0;
          cnt_n   = 3'd0;
          state_n = S_ERR;
        end
      end
      S_ERR: begin
        code_n = 16'h0;
        cnt_n  = 3'd0;
        if (tmr >= ERR_LAST) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        code_n  = 16'h0;
        cnt_n   = 3'd0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tmr_n = tmr;
    if (tmr_rst || (state_n != state)) begin
      tmr_n = '0;
    end else if (tmr != TMR_MAX) begin
      tmr_n = tmr + 1'b1;
    end
  end

  always_comb begin
    mode_n = MODE_BLANK;
    busy_n = 1'b0;
    unique case (state_n)
      S_IDLE: begin
        mode_n = MODE_BLANK;
      end
      S_ENTRY: begin
        mode_n = MODE_SHOW;
      end
      S_WAIT: begin
        mode_n = MODE_SHOW;
        busy_n = 1'b1;
      end
      S_ERR: begin
        mode_n = MODE_ERR;
        busy_n = 1'b1;
      end
      default: begin
        mode_n = MODE_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tmr          <= '0;
      entered_code <= 16'h0;
      digit_count  <= 3'd0;
      display_mode <= MODE_BLANK;
      code_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      tmr          <= tmr_n;
      entered_code <= code_n;
      digit_count  <= cnt_n;
      display_mode <= mode_n;
      code_valid   <= cv_n;
      busy         <= busy_n;
    end
  end

endmodule
